// File: rtl/hdmi_timing_pkg.sv
// Shared constants, raster helper functions and FSM encoding for the HDMI
// timing controller. Defaults describe 640x480@60.
package hdmi_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Counter width; both raster totals must fit in it.
    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;
    localparam int UF_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } tc_state_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One raster axis: wrapping position counter plus decode of the value it will
// hold next cycle, so the parent can register sync/active flags that line up
// with the counter. Used once for columns and once for lines.
module hdmi_timing_axis
    import hdmi_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             nxt_zero,
    output logic             nxt_active,
    output logic             nxt_last_active,
    output logic             nxt_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int XW    = CNT_W + 1;

    localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(TOTAL - 1);
    localparam logic [XW-1:0]    ACT_X    = XW'(ACTIVE);
    localparam logic [XW-1:0]    ACT_LAST = XW'(ACTIVE - 1);
    localparam logic [XW-1:0]    SYNC_BEG = XW'(ACTIVE + FP);
    localparam logic [XW-1:0]    SYNC_END = XW'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] nxt;
    logic [XW-1:0]    nxt_x;

    assign last  = (count == LAST_V);
    assign nxt_x = {1'b0, nxt};

    // Next position: forced to 0 when cleared, otherwise step and wrap.
    always_comb begin
        nxt = count;
        if (clear)
            nxt = '0;
        else if (advance)
            nxt = last ? '0 : count + CNT_W'(1);
    end

    assign nxt_zero        = (nxt == '0);
    assign nxt_active      = (nxt_x < ACT_X);
    assign nxt_last_active = (nxt_x == ACT_LAST);
    assign nxt_sync        = (nxt_x >= SYNC_BEG) && (nxt_x < SYNC_END);

    // Position register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else
            count <= nxt;
    end

endmodule

// File: rtl/hdmi_timing_controller.sv
// Raster sequencer for the HDMI pixel pipeline: cx/cy, hsync/vsync/de and
// sof/eol strobes, with start/stop only on frame boundaries.
// Optional macro HDMI_UNDERFLOW_MON_EN adds the upstream starvation monitor
// (underflow flag and per-frame starved-pixel count); without it those
// outputs are tied to 0 and pixel_valid is ignored.
module hdmi_timing_controller
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic             pixel_valid,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic [CNT_W-1:0] screen_width,
    output logic [CNT_W-1:0] screen_height,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             sof,
    output logic             eol,
    output logic             running,
    output logic             underflow,
    output logic [UF_W-1:0]  underflow_count
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_cfg
        $error("hdmi_timing_controller: H_TOTAL/V_TOTAL exceed counter range");
    end

    assign screen_width  = CNT_W'(H_ACTIVE);
    assign screen_height = CNT_W'(V_ACTIVE);

    tc_state_t state;
    tc_state_t st_next;
    logic      run_nxt;
    logic      clear;
    logic      frame_last;
    logic      de_nxt;

    logic h_last, h_nxt_zero, h_nxt_active, h_nxt_last_active, h_nxt_sync;
    logic v_last, v_nxt_zero, v_nxt_active, v_unused_last_active, v_nxt_sync;

    hdmi_timing_axis #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .clk             (aclk),
        .rst             (areset),
        .clear           (clear),
        .advance         (1'b1),
        .count           (cx),
        .last            (h_last),
        .nxt_zero        (h_nxt_zero),
        .nxt_active      (h_nxt_active),
        .nxt_last_active (h_nxt_last_active),
        .nxt_sync        (h_nxt_sync)
    );

    hdmi_timing_axis #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .clk             (aclk),
        .rst             (areset),
        .clear           (clear),
        .advance         (h_last),
        .count           (cy),
        .last            (v_last),
        .nxt_zero        (v_nxt_zero),
        .nxt_active      (v_nxt_active),
        .nxt_last_active (v_unused_last_active),
        .nxt_sync        (v_nxt_sync)
    );

    assign frame_last = h_last && v_last;

    // Next state: stop requests take effect only once the last pixel of the frame is shown.
    always_comb begin
        st_next = state;
        case (state)
            ST_IDLE:     if (enable) st_next = ST_RUN;
            ST_RUN:      if (!enable) st_next = frame_last ? ST_IDLE : ST_STOPPING;
            ST_STOPPING: begin
                if (enable)
                    st_next = ST_RUN;
                else if (frame_last)
                    st_next = ST_IDLE;
            end
            default:     st_next = ST_IDLE;
        endcase
    end

    // Counters sit at 0 in IDLE and on the cycle that leaves IDLE, so RUN opens at 0,0.
    assign run_nxt = (st_next != ST_IDLE);
    assign clear   = (state == ST_IDLE) || !run_nxt;
    assign de_nxt  = run_nxt && h_nxt_active && v_nxt_active;

    // FSM state and registered strobes, decoded from the next counter values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            de      <= 1'b0;
            sof     <= 1'b0;
            eol     <= 1'b0;
            hsync   <= ~SYNC_POL;
            vsync   <= ~SYNC_POL;
        end else begin
            state   <= st_next;
            running <= run_nxt;
            de      <= de_nxt;
            sof     <= run_nxt && h_nxt_zero && v_nxt_zero;
            eol     <= de_nxt && h_nxt_last_active;
            hsync   <= (run_nxt && h_nxt_sync) ? SYNC_POL : ~SYNC_POL;
            vsync   <= (run_nxt && v_nxt_sync) ? SYNC_POL : ~SYNC_POL;
        end
    end

`ifdef HDMI_UNDERFLOW_MON_EN
    logic [UF_W-1:0] uf_frame_cnt;
    logic            starved;

    assign starved = de && !pixel_valid;

    // Starvation monitor: sticky flag plus saturating per-frame count, handed over at sof.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            underflow       <= 1'b0;
            uf_frame_cnt    <= '0;
            underflow_count <= '0;
        end else begin
            if (starved)
                underflow <= 1'b1;
            if (sof) begin
                underflow_count <= uf_frame_cnt;
                uf_frame_cnt    <= starved ? UF_W'(1) : '0;
            end else if (starved && uf_frame_cnt != {UF_W{1'b1}}) begin
                uf_frame_cnt <= uf_frame_cnt + UF_W'(1);
            end
        end
    end
`else
    logic unused_pixel_valid;

    assign unused_pixel_valid = pixel_valid;
    assign underflow          = 1'b0;
    assign underflow_count    = '0;
`endif

endmodule

// File: tb/tb_hdmi_timing_controller.sv
// Directed bench for hdmi_timing_controller on a reduced 16x11 raster
// (active 8x6, hsync cols 10..12, vsync lines 7..8), with a second
// instance built for positive sync polarity.
module tb_hdmi_timing_controller;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;

`ifdef HDMI_UNDERFLOW_MON_EN
    localparam int UF_ON = 1;
`else
    localparam int UF_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst, enable, pixel_valid;

    logic [9:0]  cx, cy, sw, sh;
    logic        hsync, vsync, de, sof, eol, running, underflow;
    logic [15:0] ucount;

    logic [9:0]  p_cx, p_cy, p_sw, p_sh;
    logic        p_hsync, p_vsync, p_de, p_sof, p_eol, p_running, p_underflow;
    logic [15:0] p_ucount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hdmi_timing_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .aclk (clk), .areset (rst), .enable (enable), .pixel_valid (pixel_valid),
        .cx (cx), .cy (cy), .screen_width (sw), .screen_height (sh),
        .hsync (hsync), .vsync (vsync), .de (de), .sof (sof), .eol (eol),
        .running (running), .underflow (underflow), .underflow_count (ucount)
    );

    hdmi_timing_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) dut_pos (
        .aclk (clk), .areset (rst), .enable (enable), .pixel_valid (pixel_valid),
        .cx (p_cx), .cy (p_cy), .screen_width (p_sw), .screen_height (p_sh),
        .hsync (p_hsync), .vsync (p_vsync), .de (p_de), .sof (p_sof), .eol (p_eol),
        .running (p_running), .underflow (p_underflow), .underflow_count (p_ucount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; pixel_valid = 1'b1;
        step(3);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_de", de, 0);
        chk("rst_sof", sof, 0);
        chk("rst_eol", eol, 0);
        chk("rst_running", running, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_p_hsync", p_hsync, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_ucount", ucount, 0);
        chk("screen_width", sw, HA);
        chk("screen_height", sh, VA);

        // Idle after reset release
        rst = 1'b0;
        step(6);
        chk("idle_running", running, 0);
        chk("idle_cx", cx, 0);
        chk("idle_sof", sof, 0);

        // Start: one cycle after enable is sampled
        enable = 1'b1;
        step(1);
        chk("start_sof", sof, 1);
        chk("start_cx", cx, 0);
        chk("start_cy", cy, 0);
        chk("start_de", de, 1);
        chk("start_running", running, 1);

        // Line 0 horizontal timing
        for (int i = 0; i < 16; i++) begin
            chk("l0_cx", cx, i);
            chk("l0_cy", cy, 0);
            chk("l0_de", de, (i < 8));
            chk("l0_eol", eol, (i == 7));
            chk("l0_hsync", hsync, !(i >= 10 && i < 13));
            chk("l0_p_hsync", p_hsync, (i >= 10 && i < 13));
            chk("l0_sof", sof, (i == 0));
            step(1);
        end

        // Vertical timing, lines 1..10, checked at first and last column
        for (int l = 1; l < 11; l++) begin
            chk("v_cy", cy, l);
            chk("v_cx0", cx, 0);
            chk("v_sof", sof, 0);
            chk("v_vsync", vsync, !(l == 7 || l == 8));
            chk("v_p_vsync", p_vsync, (l == 7 || l == 8));
            chk("v_de", de, (l < 6));
            step(15);
            chk("v_cx15", cx, 15);
            chk("v_cy15", cy, l);
            chk("v_vsync15", vsync, !(l == 7 || l == 8));
            chk("v_de15", de, 0);
            step(1);
        end
        chk("sof_period", sof, 1);
        chk("wrap_cx", cx, 0);
        chk("wrap_cy", cy, 0);
        chk("wrap_vsync", vsync, 1);

        // Stop request mid-frame completes the frame then idles
        step(48);
        chk("stop_at_cx", cx, 0);
        chk("stop_at_cy", cy, 3);
        enable = 1'b0;
        step(1);
        chk("stopping_running", running, 1);
        chk("stopping_cx", cx, 1);
        step(126);
        chk("frame_end_cx", cx, 15);
        chk("frame_end_cy", cy, 10);
        chk("frame_end_running", running, 1);
        step(1);
        chk("stopped_running", running, 0);
        chk("stopped_cx", cx, 0);
        chk("stopped_cy", cy, 0);
        chk("stopped_sof", sof, 0);
        chk("stopped_de", de, 0);
        chk("stopped_hsync", hsync, 1);
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("idle_no_sof", sof, 0);
            chk("idle_hold_cx", cx, 0);
        end

        // Restart, then re-enable during STOPPING
        enable = 1'b1;
        step(1);
        chk("restart_sof", sof, 1);
        chk("restart_running", running, 1);
        step(48);
        chk("re_cy", cy, 3);
        enable = 1'b0;
        step(16);
        chk("re_stop_running", running, 1);
        chk("re_stop_cx", cx, 0);
        chk("re_stop_cy", cy, 4);
        enable = 1'b1;
        step(1);
        chk("re_run_cx", cx, 1);
        chk("re_run_cy", cy, 4);
        step(111);
        chk("cont_sof", sof, 1);
        chk("cont_cx", cx, 0);
        chk("cont_cy", cy, 0);
        chk("cont_running", running, 1);

        // Asynchronous reset mid-frame
        step(37);
        chk("pre_rst_cx", cx, 5);
        chk("pre_rst_cy", cy, 2);
        chk("pre_rst_de", de, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cx", cx, 0);
        chk("arst_cy", cy, 0);
        chk("arst_de", de, 0);
        chk("arst_running", running, 0);
        chk("arst_hsync", hsync, 1);
        step(2);
        rst = 1'b0;
        step(1);
        chk("post_rst_sof", sof, 1);
        chk("post_rst_cx", cx, 0);
        chk("post_rst_running", running, 1);

        // Starvation: 10 active cycles without valid data in this frame
        pixel_valid = 1'b0;
        step(8);
        pixel_valid = 1'b1;
        chk("uf_flag", underflow, UF_ON);
        step(8);
        chk("uf_cx", cx, 0);
        chk("uf_cy", cy, 1);
        pixel_valid = 1'b0;
        step(2);
        pixel_valid = 1'b1;
        chk("uf_cx2", cx, 2);
        step(158);
        chk("uf_next_sof", sof, 1);
        chk("uf_count_before", ucount, 0);
        step(1);
        chk("uf_count", ucount, (UF_ON != 0) ? 10 : 0);
        chk("uf_sticky", underflow, UF_ON);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
